// File: rtl/regfile_pkg.sv
// Shared constants and the pending-mask decode for the register-file write arbiter.
package regfile_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;

  localparam int PORT_ALU = 0;
  localparam int PORT_MEM = 1;

  // Register 0 is hard-wired, so it never shows up as pending.
  function automatic logic [NUM_REGS_DEF-1:0] reg_onehot(
    input logic [ADDR_W_DEF-1:0] addr,
    input logic                  en
  );
    logic [NUM_REGS_DEF-1:0] v;
    v = '0;
    if (en && (addr != '0)) v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_req_buffer.sv
// One-entry valid/ready holding buffer for a writeback requester.
module wb_req_buffer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] reg_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] reg_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] reg_q;
  logic [DATA_W-1:0] data_q;

  // A granted entry leaves this edge, so the slot can be refilled at once.
  assign ready_o = !valid_q || grant_i;
  assign valid_o = valid_q;
  assign reg_o   = reg_q;
  assign data_o  = data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
    end else if (valid_i && ready_o) begin
      valid_q <= 1'b1;
      reg_q   <= reg_i;
      data_q  <= data_i;
    end else if (grant_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port between the ALU and load paths.
// Defining REG_ARB_STATS_EN adds saturating grant/conflict counters.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_reg,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 regWrite,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pending_mask,
`ifdef REG_ARB_STATS_EN
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1,
  output logic [15:0]          conflict_cnt,
`endif
  output logic                 busy
);

  logic [1:0]        buf_valid;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] buf_reg  [2];
  logic [DATA_W-1:0] buf_data [2];

  logic              last_q;
  logic              stage_valid_q;
  logic              regwrite_q;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  wb_req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_alu (
    .clk     (clk),
    .reset   (reset),
    .valid_i (alu_valid),
    .reg_i   (alu_reg),
    .data_i  (alu_data),
    .grant_i (grant[PORT_ALU]),
    .ready_o (alu_ready),
    .valid_o (buf_valid[PORT_ALU]),
    .reg_o   (buf_reg[PORT_ALU]),
    .data_o  (buf_data[PORT_ALU])
  );

  wb_req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_mem (
    .clk     (clk),
    .reset   (reset),
    .valid_i (mem_valid),
    .reg_i   (mem_reg),
    .data_i  (mem_data),
    .grant_i (grant[PORT_MEM]),
    .ready_o (mem_ready),
    .valid_o (buf_valid[PORT_MEM]),
    .reg_o   (buf_reg[PORT_MEM]),
    .data_o  (buf_data[PORT_MEM])
  );

  // On a tie the port that was not granted last wins.
  assign grant[PORT_ALU] = buf_valid[PORT_ALU] &&
                           (!buf_valid[PORT_MEM] || (last_q == 1'(PORT_MEM)));
  assign grant[PORT_MEM] = buf_valid[PORT_MEM] &&
                           (!buf_valid[PORT_ALU] || (last_q == 1'(PORT_ALU)));

  assign wreg_d  = grant[PORT_MEM] ? buf_reg[PORT_MEM]  : buf_reg[PORT_ALU];
  assign wdata_d = grant[PORT_MEM] ? buf_data[PORT_MEM] : buf_data[PORT_ALU];

  // A register-0 entry still occupies the stage for a cycle but never strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q        <= 1'(PORT_MEM);
      stage_valid_q <= 1'b0;
      regwrite_q    <= 1'b0;
      wreg_q        <= '0;
      wdata_q       <= '0;
    end else begin
      stage_valid_q <= |grant;
      regwrite_q    <= (|grant) && (wreg_d != '0);
      if (|grant) begin
        last_q  <= grant[PORT_MEM];
        wreg_q  <= wreg_d;
        wdata_q <= wdata_d;
      end
    end
  end

  assign regWrite   = regwrite_q;
  assign write_reg  = wreg_q;
  assign write_data = wdata_q;
  assign busy       = (|buf_valid) || stage_valid_q;

  assign pending_mask = reg_onehot(buf_reg[PORT_ALU], buf_valid[PORT_ALU]) |
                        reg_onehot(buf_reg[PORT_MEM], buf_valid[PORT_MEM]) |
                        reg_onehot(wreg_q, regwrite_q);

`ifdef REG_ARB_STATS_EN
  logic [15:0] gcnt0_q, gcnt1_q, ccnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else begin
      if (grant[PORT_ALU] && (gcnt0_q != 16'hFFFF)) gcnt0_q <= gcnt0_q + 16'd1;
      if (grant[PORT_MEM] && (gcnt1_q != 16'hFFFF)) gcnt1_q <= gcnt1_q + 16'd1;
      if ((&buf_valid) && (ccnt_q != 16'hFFFF))     ccnt_q  <= ccnt_q + 16'd1;
    end
  end

  assign grant_cnt0   = gcnt0_q;
  assign grant_cnt1   = gcnt1_q;
  assign conflict_cnt = ccnt_q;
`endif

endmodule
